// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//
// Central stall/flush sequencer for the 5-stage pipeline. It merges three
// hazard sources into one prioritised set of per-stage write enables,
// bubbles and flushes:
//   1. multi-cycle data-memory waits in MEM (freeze everything up to EX/MEM)
//   2. taken branch/jump redirects resolved in EX (flush IF/ID and ID/EX)
//   3. load-use hazards between the load in EX and its consumer in ID
// It also runs a small memory-wait FSM with a sticky timeout flag, and keeps
// saturating debug counters for each kind of event.
//
// Parameters
//   CNT_W        width of each saturating event counter
//   MEM_TIMEOUT  consecutive memory-wait cycles that set mem_timeout (>=1)
//
// Ports
//   clk, rst_n                        clock, synchronous active-low reset
//   id_ex_mem_read, id_ex_rd          load flag / destination of instr in EX
//   if_id_rs1, if_id_rs2              sources of instr in ID
//   ex_mem_mem_req, dmem_ready        data-memory access in MEM / completion
//   branch_taken                      branch/jump resolved taken in EX
//   pc_write .. ex_mem_write          pipeline register load enables
//   id_ex_bubble, mem_wb_bubble       bubble insertion selects
//   if_id_flush, id_ex_flush          clear-to-NOP controls
//   mem_timeout                       sticky memory-wait timeout flag
//   stall_count, mem_stall_count,
//   flush_count                       saturating debug event counters

module pipeline_stall_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             ex_mem_mem_req,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] mem_stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // The wait counter is at least 8 bits but grows if MEM_TIMEOUT needs more.
    localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W:0]   wait_cnt_inc;

    logic mem_freeze;
    logic load_use;
    logic branch_win;
    logic load_use_win;

    // Hazard detection and priority resolution. A memory freeze masks both
    // branch and load-use; they stay on the inputs and are re-presented once
    // the memory completes. A taken branch masks load-use because the
    // dependent instruction in ID is about to be flushed anyway.
    always_comb begin
        mem_freeze   = ex_mem_mem_req && !dmem_ready;
        load_use     = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                       ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
        branch_win   = !mem_freeze && branch_taken;
        load_use_win = !mem_freeze && !branch_taken && load_use;
        wait_cnt_inc = {1'b0, wait_cnt} + (WAIT_W + 1)'(1);
    end

    // Next-state logic. The priority rules behave the same in both states;
    // MEM_WAIT exits in the first cycle the freeze condition drops, with no
    // separate recovery cycle.
    always_comb begin
        next_state = state;
        case (state)
            RUN:      next_state = mem_freeze ? MEM_WAIT : RUN;
            MEM_WAIT: next_state = mem_freeze ? MEM_WAIT : RUN;
            default:  next_state = RUN;
        endcase
    end

    // Pipeline control outputs. While reset is held the whole pipe is
    // disabled and cleared so no partial instruction leaks out of reset.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        if (!rst_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
        end else if (mem_freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (branch_taken) begin
            pc_write      = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
        end else if (load_use) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_bubble  = 1'b1;
        end
    end

    // State, wait tracking and event counters. Only the counter of the
    // winning rule advances, and every counter sticks at all-ones. The
    // timeout flag is sticky until reset; freezing carries on regardless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= RUN;
            wait_cnt        <= '0;
            mem_timeout     <= 1'b0;
            stall_count     <= '0;
            mem_stall_count <= '0;
            flush_count     <= '0;
        end else begin
            state <= next_state;
            if (mem_freeze) begin
                if (wait_cnt != TIMEOUT_VAL) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                if (wait_cnt_inc == {1'b0, TIMEOUT_VAL}) begin
                    mem_timeout <= 1'b1;
                end
                if (mem_stall_count != '1) begin
                    mem_stall_count <= mem_stall_count + CNT_W'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
            if (branch_win && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
            if (load_use_win && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule
